// File: rtl/multiplicador_secuencial.sv
// Sequential unsigned shift-add multiplier: one partial-product iteration per clock,
// START/DONE handshake shared with the sequential divider.
module multiplicador_secuencial #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   md,
    input  logic [WIDTH-1:0]   mr,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] r,
    output logic               ovf,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   s;

    // Handshake: start is a request seen only in IDLE; done is a one-cycle
    // pulse during which r/ovf are valid; busy covers RUN and FIN.
    always_comb begin
        s = acc + (q[0] ? {1'b0, mdr} : '0);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            ovf   <= 1'b0;
            mdr   <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mdr   <= md;
                        q     <= mr;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= {1'b0, s[WIDTH:1]};
                    q   <= {s[0], q[WIDTH-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Product is the shifted {acc,q}; its carry-free top bit is dropped.
                        r     <= {s, q[WIDTH-1:1]};
                        ovf   <= |s[WIDTH:1];
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
